// File: rtl/bm_loader.sv
// Serial-to-parallel front end for the bitonic merge network: gathers N words into a lane vector
// and emits it with a one-cycle valid pulse. Define BM_LOADER_PAD_EN to allow short frames padded to N lanes.
module bm_loader #(
    parameter int DATA_WIDTH   = 4,
    parameter int NUM_BM_CHANN = 1,
    localparam int N  = 2 ** NUM_BM_CHANN,
    localparam int VW = DATA_WIDTH * N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  asc_in,
    output logic [0:VW-1]         c_out,
    output logic                  asc_out,
    output logic                  y_valid,
    output logic [7:0]            frame_cnt
);

`ifdef BM_LOADER_PAD_EN
    typedef enum logic [0:0] {ST_FILL, ST_PAD} state_t;
`else
    typedef enum logic [0:0] {ST_FILL} state_t;
    logic unused_s_last;
    assign unused_s_last = s_last;
`endif

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   fill_q [N];
    logic [DATA_WIDTH-1:0]   fill_d [N];
    logic [NUM_BM_CHANN-1:0] idx_q, idx_d;
    logic                    shadow_q, shadow_d;
    logic [0:VW-1]           c_q, c_d;
    logic                    asc_q, asc_d;
    logic                    yv_q, yv_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    rdy_q, rdy_d;
    logic                    emit;

    localparam logic [NUM_BM_CHANN-1:0] LAST_IDX = NUM_BM_CHANN'(N - 1);

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        c_d      = c_q;
        asc_d    = asc_q;
        yv_d     = 1'b0;
        cnt_d    = cnt_q;
        emit     = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (s_valid && rdy_q) begin
                    fill_d[idx_q] = s_data;
                    if (idx_q == '0) begin
                        shadow_d = asc_in;
                    end
                    if (idx_q == LAST_IDX) begin
                        emit = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
`ifdef BM_LOADER_PAD_EN
                        if (s_last) begin
                            state_d = ST_PAD;
                        end
`endif
                    end
                end
            end
`ifdef BM_LOADER_PAD_EN
            ST_PAD: begin
                // Pad value follows the frame direction so pads sort to the tail.
                fill_d[idx_q] = {DATA_WIDTH{shadow_q}};
                if (idx_q == LAST_IDX) begin
                    emit = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_FILL;
        endcase

        // Emit uses the just-written fill lanes so the vector appears one cycle after the last word.
        if (emit) begin
            for (int k = 0; k < N; k++) begin
                c_d[k*DATA_WIDTH +: DATA_WIDTH] = fill_d[k];
            end
            asc_d   = shadow_d;
            yv_d    = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            idx_d   = '0;
            state_d = ST_FILL;
        end

        rdy_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FILL;
            fill_q   <= '{default: '0};
            idx_q    <= '0;
            shadow_q <= 1'b0;
            c_q      <= '0;
            asc_q    <= 1'b0;
            yv_q     <= 1'b0;
            cnt_q    <= 8'd0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            c_q      <= c_d;
            asc_q    <= asc_d;
            yv_q     <= yv_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
        end
    end

    assign s_ready   = rdy_q;
    assign c_out     = c_q;
    assign asc_out   = asc_q;
    assign y_valid   = yv_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_bm_loader.sv
// Directed test of bm_loader with 4 lanes of 4-bit keys; each check is an immediate assertion.
module tb_bm_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [3:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        asc_in;
    logic [0:15] c_out;
    logic        asc_out;
    logic        y_valid;
    logic [7:0]  frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    int ycount;

    always #5 clk = ~clk;

    bm_loader #(.DATA_WIDTH(4), .NUM_BM_CHANN(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .asc_in   (asc_in),
        .c_out    (c_out),
        .asc_out  (asc_out),
        .y_valid  (y_valid),
        .frame_cnt(frame_cnt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
        $display("check %-14s observed %h expected %h", tag, obs, expv);
    endtask

    // Present one word for one clock edge, then look at outputs just after that edge.
    task automatic send(input logic [3:0] w, input logic last, input logic asc);
        s_valid = 1'b1;
        s_data  = w;
        s_last  = last;
        asc_in  = asc;
        @(posedge clk);
        #1;
        if (y_valid === 1'b1) ycount++;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
        if (y_valid === 1'b1) ycount++;
    endtask

    task automatic send_frame(input logic [15:0] v, input logic asc);
        send(v[15:12], 1'b0, asc);
        send(v[11:8],  1'b0, asc);
        send(v[7:4],   1'b0, asc);
        send(v[3:0],   1'b0, asc);
    endtask

    logic [15:0] frames [3];

    initial begin
        frames[0] = 16'hABCD;
        frames[1] = 16'h0F1E;
        frames[2] = 16'h5A5A;
        ycount  = 0;
        rst     = 1'b0;
        s_valid = 1'b1;
        s_data  = 4'h7;
        s_last  = 1'b0;
        asc_in  = 1'b1;

        // Reset held with valid input present
        repeat (2) @(posedge clk);
        #1;
        check("rst_c_out", c_out, 16'h0000);
        check("rst_y_valid", {15'd0, y_valid}, 16'd0);
        check("rst_s_ready", {15'd0, s_ready}, 16'd0);
        check("rst_frame_cnt", {8'd0, frame_cnt}, 16'd0);
        rst     = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rel_s_ready", {15'd0, s_ready}, 16'd1);

        // Single frame 3,1,4,2 ascending
        send(4'h3, 1'b0, 1'b1);
        send(4'h1, 1'b0, 1'b1);
        send(4'h4, 1'b0, 1'b1);
        check("f1_no_yv_early", {15'd0, y_valid}, 16'd0);
        send(4'h2, 1'b0, 1'b1);
        check("f1_y_valid", {15'd0, y_valid}, 16'd1);
        check("f1_c_out", c_out, 16'h3142);
        check("f1_asc_out", {15'd0, asc_out}, 16'd1);
        check("f1_frame_cnt", {8'd0, frame_cnt}, 16'd1);
        idle();
        check("f1_pulse_end", {15'd0, y_valid}, 16'd0);
        check("f1_c_hold", c_out, 16'h3142);

        // Three frames streamed with no gaps
        ycount = 0;
        for (int f = 0; f < 3; f++) begin
            check("st_s_ready", {15'd0, s_ready}, 16'd1);
            send_frame(frames[f], f[0]);
            check("st_y_valid", {15'd0, y_valid}, 16'd1);
            check("st_c_out", c_out, frames[f]);
            check("st_asc_out", {15'd0, asc_out}, {15'd0, f[0]});
        end
        check("st_frame_cnt", {8'd0, frame_cnt}, 16'd4);
        check("st_ycount", ycount[15:0], 16'd3);
        idle();

        // Two words, reset mid-frame, then a gapped frame
        send(4'hE, 1'b0, 1'b1);
        send(4'hD, 1'b0, 1'b1);
        s_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mr_async_c_out", c_out, 16'h0000);
        check("mr_async_cnt", {8'd0, frame_cnt}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        ycount = 0;
        send(4'h5, 1'b0, 1'b0);
        idle();
        send(4'h6, 1'b0, 1'b0);
        idle();
        idle();
        send(4'h7, 1'b0, 1'b0);
        send(4'h8, 1'b0, 1'b0);
        check("mr_c_out", c_out, 16'h5678);
        check("mr_asc_out", {15'd0, asc_out}, 16'd0);
        check("mr_frame_cnt", {8'd0, frame_cnt}, 16'd1);
        idle();
        check("mr_ycount", ycount[15:0], 16'd1);

`ifdef BM_LOADER_PAD_EN
        // Short frame padded with ones (ascending) then zeros (descending)
        for (int a = 1; a >= 0; a--) begin
            send(4'h9, 1'b0, a[0]);
            send(4'h2, 1'b1, a[0]);
            s_valid = 1'b0;
            s_last  = 1'b0;
            check("pad_rdy_low1", {15'd0, s_ready}, 16'd0);
            idle();
            check("pad_rdy_low2", {15'd0, s_ready}, 16'd0);
            check("pad_no_yv", {15'd0, y_valid}, 16'd0);
            idle();
            check("pad_y_valid", {15'd0, y_valid}, 16'd1);
            check("pad_rdy_back", {15'd0, s_ready}, 16'd1);
            check("pad_c_out", c_out, (a == 1) ? 16'h92FF : 16'h9200);
            check("pad_asc_out", {15'd0, asc_out}, {15'd0, a[0]});
        end
`else
        // s_last has no effect: frame still takes four words
        send(4'h9, 1'b0, 1'b1);
        send(4'h2, 1'b1, 1'b1);
        check("nopad_rdy", {15'd0, s_ready}, 16'd1);
        check("nopad_no_yv", {15'd0, y_valid}, 16'd0);
        send(4'h4, 1'b0, 1'b1);
        send(4'h5, 1'b0, 1'b1);
        check("nopad_y_valid", {15'd0, y_valid}, 16'd1);
        check("nopad_c_out", c_out, 16'h9245);
`endif
        idle();

        // 256 frames wrap the frame counter
        rst = 1'b0;
        #1;
        rst = 1'b1;
        idle();
        ycount = 0;
        for (int f = 0; f < 256; f++) begin
            send_frame(16'h1234, 1'b0);
            if (f == 254) check("wrap_cnt_255", {8'd0, frame_cnt}, 16'd255);
        end
        check("wrap_cnt_0", {8'd0, frame_cnt}, 16'd0);
        check("wrap_ycount", ycount[15:0], 16'd256);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
